// File: rtl/bus_xfer_sequencer.sv
// Strobe sequencer for a shared-bus register file: turns a "move src -> dst"
// request into registered ENABLE / LOAD / COUNT strobes timed for registered register outputs.
module bus_xfer_sequencer #(
    parameter int NUM_REGS  = 8,
    parameter int SEL_WIDTH = 3
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 REQ_VALID,
    output logic                 REQ_READY,
    input  logic [SEL_WIDTH-1:0] REQ_SRC,
    input  logic [SEL_WIDTH-1:0] REQ_DST,
    input  logic                 REQ_INC,
    output logic [NUM_REGS-1:0]  ENABLE,
    output logic [NUM_REGS-1:0]  LOAD,
    output logic [NUM_REGS-1:0]  COUNT,
    output logic                 DONE,
    output logic                 ERR,
    output logic                 BUSY
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_LATCH = 3'd2,
        ST_INC   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t               state, state_next;
    logic [SEL_WIDTH-1:0] src_reg, src_next;
    logic [SEL_WIDTH-1:0] dst_reg, dst_next;
    logic                 inc_reg, inc_next;
    logic [NUM_REGS-1:0]  enable_next, load_next, count_next;
    logic                 done_next, err_next;
    logic                 req_ok;

    function automatic logic [NUM_REGS-1:0] decode(input logic [SEL_WIDTH-1:0] idx);
        return NUM_REGS'(1) << idx;
    endfunction

    assign req_ok    = (int'(REQ_SRC) < NUM_REGS) && (int'(REQ_DST) < NUM_REGS);
    assign REQ_READY = (state == ST_IDLE) && RESET;
    assign BUSY      = (state != ST_IDLE);

    always_comb begin
        state_next  = state;
        src_next    = src_reg;
        dst_next    = dst_reg;
        inc_next    = inc_reg;
        err_next    = 1'b0;
        enable_next = '0;
        load_next   = '0;
        count_next  = '0;
        done_next   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    if (req_ok) begin
                        src_next   = REQ_SRC;
                        dst_next   = REQ_DST;
                        inc_next   = REQ_INC;
                        state_next = ST_DRIVE;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_DRIVE: state_next = ST_LATCH;
            ST_LATCH: state_next = inc_reg ? ST_INC : ST_DONE;
            ST_INC:   state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase

        // Strobes are decoded from the upcoming state so they come straight out of flops.
        case (state_next)
            ST_DRIVE: enable_next = decode(src_next);
            ST_LATCH: begin
                enable_next = decode(src_reg);
                if (src_reg != dst_reg) load_next = decode(dst_reg);
            end
            ST_INC:   count_next = decode(src_reg);
            ST_DONE:  done_next  = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state   <= ST_IDLE;
            src_reg <= '0;
            dst_reg <= '0;
            inc_reg <= 1'b0;
            ENABLE  <= '0;
            LOAD    <= '0;
            COUNT   <= '0;
            DONE    <= 1'b0;
            ERR     <= 1'b0;
        end else begin
            state   <= state_next;
            src_reg <= src_next;
            dst_reg <= dst_next;
            inc_reg <= inc_next;
            ENABLE  <= enable_next;
            LOAD    <= load_next;
            COUNT   <= count_next;
            DONE    <= done_next;
            ERR     <= err_next;
        end
    end

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Directed bench for bus_xfer_sequencer with a small behavioural register file
// (registered output stage) hanging off the strobes.
module tb_bus_xfer_sequencer;

    localparam int NUM_REGS  = 8;
    localparam int SEL_WIDTH = 4;

    logic                 CLOCK;
    logic                 RESET;
    logic                 REQ_VALID;
    logic                 REQ_READY;
    logic [SEL_WIDTH-1:0] REQ_SRC;
    logic [SEL_WIDTH-1:0] REQ_DST;
    logic                 REQ_INC;
    logic [NUM_REGS-1:0]  ENABLE;
    logic [NUM_REGS-1:0]  LOAD;
    logic [NUM_REGS-1:0]  COUNT;
    logic                 DONE;
    logic                 ERR;
    logic                 BUSY;

    int errors = 0;
    int checks = 0;

    bus_xfer_sequencer #(.NUM_REGS(NUM_REGS), .SEL_WIDTH(SEL_WIDTH)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_SRC(REQ_SRC), .REQ_DST(REQ_DST), .REQ_INC(REQ_INC),
        .ENABLE(ENABLE), .LOAD(LOAD), .COUNT(COUNT),
        .DONE(DONE), .ERR(ERR), .BUSY(BUSY)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Register file model: DATA_OUT enable is registered, so the bus follows ENABLE one edge late.
    logic [15:0]         regs [NUM_REGS] = '{16'h00FF, 16'h1111, 16'h1234, 16'h0000,
                                             16'hBEEF, 16'h0000, 16'h6666, 16'h0000};
    logic [NUM_REGS-1:0] out_en = '0;
    logic [15:0]         bus;

    always @(posedge CLOCK) begin
        out_en <= ENABLE;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (LOAD[i])       regs[i] <= bus;
            else if (COUNT[i]) regs[i] <= regs[i] + 16'd1;
        end
    end

    always_comb begin
        bus = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (out_en[i]) bus = regs[i];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic request(input logic [SEL_WIDTH-1:0] s, input logic [SEL_WIDTH-1:0] d,
                           input logic inc);
        REQ_SRC   = s;
        REQ_DST   = d;
        REQ_INC   = inc;
        REQ_VALID = 1'b1;
    endtask

    logic [SEL_WIDTH-1:0] src_tab [3] = '{4'd1, 4'd6, 4'd3};
    logic [SEL_WIDTH-1:0] dst_tab [3] = '{4'd7, 4'd2, 4'd5};
    logic                 inc_tab [3] = '{1'b0, 1'b1, 1'b0};

    initial begin
        int k, cyc, accepts, dones, multi, rdy_bad, load_seen, last_done;
        logic accept_now;

        RESET = 1'b0; REQ_VALID = 1'b0; REQ_SRC = '0; REQ_DST = '0; REQ_INC = 1'b0;
        tick(); tick();
        check("rst_enable", ENABLE, 0);
        check("rst_load", LOAD, 0);
        check("rst_count", COUNT, 0);
        check("rst_done", DONE, 0);
        check("rst_err", ERR, 0);
        check("rst_busy", BUSY, 0);
        RESET = 1'b1;
        #1;
        check("rst_ready", REQ_READY, 1);

        // src=2 -> dst=5, no increment
        request(4'd2, 4'd5, 1'b0);
        tick();
        REQ_VALID = 1'b0;
        check("t1_drive_en", ENABLE, 8'h04);
        check("t1_drive_ld", LOAD, 0);
        check("t1_drive_rdy", REQ_READY, 0);
        check("t1_drive_busy", BUSY, 1);
        tick();
        check("t1_latch_en", ENABLE, 8'h04);
        check("t1_latch_ld", LOAD, 8'h20);
        check("t1_latch_done", DONE, 0);
        tick();
        check("t1_done", DONE, 1);
        check("t1_done_en", ENABLE, 0);
        check("t1_done_ld", LOAD, 0);
        check("t1_r5", regs[5], 16'h1234);
        tick();
        check("t1_idle_done", DONE, 0);
        check("t1_idle_rdy", REQ_READY, 1);

        // src=0 (PC) -> dst=3 with post-increment
        request(4'd0, 4'd3, 1'b1);
        tick();
        REQ_VALID = 1'b0;
        check("t2_drive_en", ENABLE, 8'h01);
        tick();
        check("t2_latch_ld", LOAD, 8'h08);
        check("t2_latch_cnt", COUNT, 0);
        tick();
        check("t2_inc_cnt", COUNT, 8'h01);
        check("t2_inc_en", ENABLE, 0);
        check("t2_inc_ld", LOAD, 0);
        check("t2_inc_done", DONE, 0);
        check("t2_r3", regs[3], 16'h00FF);
        tick();
        check("t2_done", DONE, 1);
        check("t2_done_cnt", COUNT, 0);
        check("t2_pc", regs[0], 16'h0100);
        tick();

        // out-of-range source index
        request(4'd9, 4'd1, 1'b0);
        tick();
        REQ_VALID = 1'b0;
        check("t3_err", ERR, 1);
        check("t3_strobes", {ENABLE, LOAD, COUNT}, 0);
        check("t3_ready", REQ_READY, 1);
        check("t3_busy", BUSY, 0);
        tick();
        check("t3_err_clr", ERR, 0);

        // src == dst: drive without load
        load_seen = 0;
        request(4'd4, 4'd4, 1'b0);
        tick();
        REQ_VALID = 1'b0;
        check("t4_drive_en", ENABLE, 8'h10);
        if (LOAD != 0) load_seen++;
        tick();
        check("t4_latch_en", ENABLE, 8'h10);
        if (LOAD != 0) load_seen++;
        tick();
        check("t4_done", DONE, 1);
        check("t4_load_seen", load_seen, 0);
        check("t4_r4", regs[4], 16'hBEEF);
        tick();

        // back-to-back with REQ_VALID held high
        k = 0; cyc = 0; accepts = 0; dones = 0; multi = 0; rdy_bad = 0; last_done = 0;
        request(src_tab[0], dst_tab[0], inc_tab[0]);
        while (cyc < 60 && dones < 3) begin
            accept_now = REQ_READY && REQ_VALID;
            tick();
            cyc++;
            if (accept_now) begin
                accepts++;
                k++;
                if (k < 3) request(src_tab[k], dst_tab[k], inc_tab[k]);
                else REQ_VALID = 1'b0;
            end
            if (DONE) begin
                dones++;
                last_done = cyc;
            end
            if ($countones(ENABLE) > 1) multi++;
            if (BUSY && REQ_READY) rdy_bad++;
        end
        REQ_VALID = 1'b0;
        check("t5_accepts", accepts, 3);
        check("t5_dones", dones, 3);
        check("t5_last_done_cyc", last_done, 12);
        check("t5_multi_enable", multi, 0);
        check("t5_ready_busy", rdy_bad, 0);
        check("t5_r7", regs[7], 16'h1111);
        check("t5_r2", regs[2], 16'h6666);
        check("t5_r6", regs[6], 16'h6667);
        check("t5_r5", regs[5], 16'h00FF);
        tick();

        // reset asserted during LATCH
        request(4'd1, 4'd0, 1'b0);
        tick();
        REQ_VALID = 1'b0;
        tick();
        check("t6_latch_ld", LOAD, 8'h01);
        #2 RESET = 1'b0;
        #1;
        check("t6_async_en", ENABLE, 0);
        check("t6_async_ld", LOAD, 0);
        check("t6_async_busy", BUSY, 0);
        tick();
        check("t6_no_done", DONE, 0);
        check("t6_r0_kept", regs[0], 16'h0100);
        RESET = 1'b1;
        request(4'd4, 4'd0, 1'b0);
        tick();
        REQ_VALID = 1'b0;
        check("t6_re_drive", ENABLE, 8'h10);
        tick();
        tick();
        check("t6_re_done", DONE, 1);
        check("t6_r0", regs[0], 16'hBEEF);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
